dsp_sequencer: RTL and testbench

DSP_SEQUENCER -- requirements
Module: dsp_sequencer

---
 rtl/dsp_pkg.sv | 35 +++
 rtl/dsp_sequencer_if.sv | 14 +
 rtl/dsp_sequencer.sv | 145 ++++++++++++++
 tb/tb_dsp_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: instruction encoding, NOP word, sequencer FSM
// states and default widths. Also imported by dsp_core.
package dsp_pkg;

  localparam int PROG_AW        = 10;  // program memory address width
  localparam int PIPE_DEPTH_DEF = 4;   // dsp_core: read, ex1, ex2, writeback

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_MAC = 6'd1,
    OP_ADD = 6'd2,
    OP_MUL = 6'd3,
    OP_LD  = 6'd4,
    OP_ST  = 6'd5
  } opcode_t;

  typedef struct packed {
    opcode_t    op;
    logic [4:0] dst;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic [4:0] imm;
  } instr_t;

  localparam int     INSTR_W   = $bits(instr_t);  // 26
  localparam instr_t INSTR_NOP = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/dsp_sequencer_if.sv
// Program memory read bus between dsp_sequencer (master) and the
// synchronous-read program memory (slave). Read data is valid the cycle
// after pmem_rd_en.
interface dsp_sequencer_if #(
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int INSTR_WIDTH     = 26
);
  logic                       pmem_rd_en;
  logic [PROG_ADDR_WIDTH-1:0] pmem_rd_addr;
  logic [INSTR_WIDTH-1:0]     pmem_rd_data;

  modport master (output pmem_rd_en, pmem_rd_addr, input  pmem_rd_data);
  modport slave  (input  pmem_rd_en, pmem_rd_addr, output pmem_rd_data);
endinterface

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: on an accepted sample tick, streams prog_len program words
// from program memory into dsp_core, waits for the core pipeline to drain,
// then pulses frame_done. Ticks arriving while busy are counted as overruns.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   sample_tick       sample period start pulse
//   enable            permits acceptance of new ticks
//   prog_len          instructions per frame (clamped to 2**PROG_ADDR_WIDTH)
//   pmem              program memory read bus (master)
//   instr_out         registered instruction to dsp_core, NOP when idle
//   busy, frame_done  frame in progress / last writeback complete pulse
//   overrun*          sticky missed-tick flag, saturating count, clear
module dsp_sequencer
  import dsp_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = PROG_AW,
  parameter int INSTR_WIDTH     = INSTR_W,
  parameter int PIPE_DEPTH      = PIPE_DEPTH_DEF,
  parameter int OVR_CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_tick,
  input  logic                     enable,
  input  logic [PROG_ADDR_WIDTH:0] prog_len,
  dsp_sequencer_if.master          pmem,
  output logic [INSTR_WIDTH-1:0]   instr_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic [OVR_CNT_WIDTH-1:0] overrun_count,
  input  logic                     overrun_clr
);

  // Drain covers memory read latency + instr_out register + core pipeline.
  localparam int DRAIN_CYC = PIPE_DEPTH + 2;
  localparam int DCW       = $clog2(DRAIN_CYC);
  localparam logic [DCW-1:0]             DRAIN_LAST = DCW'(DRAIN_CYC - 1);
  localparam logic [DCW-1:0]             DCNT_ONE   = DCW'(1);
  localparam logic [PROG_ADDR_WIDTH:0]   MAX_LEN    = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};
  localparam logic [PROG_ADDR_WIDTH:0]   LEN_ONE    = (PROG_ADDR_WIDTH+1)'(1);
  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE     = PROG_ADDR_WIDTH'(1);
  localparam logic [OVR_CNT_WIDTH-1:0]   OVR_ONE    = OVR_CNT_WIDTH'(1);

  seq_state_t                 state_q, state_d;
  logic [PROG_ADDR_WIDTH:0]   n_q, n_d;
  logic [PROG_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                       rd_en_q, rd_en_d;
  logic                       rd_vld_q, rd_vld_d;   // read data arrives this cycle
  logic [INSTR_WIDTH-1:0]     instr_q, instr_d;
  logic [DCW-1:0]             dcnt_q, dcnt_d;
  logic                       ovr_q, ovr_d;
  logic [OVR_CNT_WIDTH-1:0]   ovr_cnt_q, ovr_cnt_d;

  logic                     accept, last_fetch, ovr_evt;
  logic [PROG_ADDR_WIDTH:0] len_clamp;

  assign len_clamp  = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign accept     = (state_q == ST_IDLE) && sample_tick && enable;
  assign last_fetch = ({1'b0, pc_q} == (n_q - LEN_ONE));
  // busy includes the DONE cycle, so a tick there is an overrun too
  assign ovr_evt    = sample_tick && busy;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (len_clamp == '0) ? ST_DRAIN : ST_FETCH;
      ST_FETCH: if (last_fetch) state_d = ST_DRAIN;
      ST_DRAIN: if (dcnt_q == DRAIN_LAST) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_DONE);
  end

  // Datapath: fetch address, read pipeline, drain counter, overrun
  always_comb begin
    n_d     = accept ? len_clamp : n_q;
    pc_d    = pc_q;
    rd_en_d = 1'b0;
    if (accept) begin
      pc_d    = '0;
      rd_en_d = (len_clamp != '0);
    end else if (state_q == ST_FETCH && !last_fetch) begin
      pc_d    = pc_q + PC_ONE;
      rd_en_d = 1'b1;
    end

    rd_vld_d = rd_en_q;
    instr_d  = rd_vld_q ? pmem.pmem_rd_data : INSTR_WIDTH'(INSTR_NOP);
    dcnt_d   = (state_q == ST_DRAIN) ? dcnt_q + DCNT_ONE : '0;

    // Clear loses to a same-cycle event so that tick is not lost.
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_clr) begin
      ovr_d     = ovr_evt;
      ovr_cnt_d = ovr_evt ? OVR_ONE : '0;
    end else if (ovr_evt) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + OVR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q       <= '0;
      pc_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      instr_q   <= INSTR_WIDTH'(INSTR_NOP);
      dcnt_q    <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      n_q       <= n_d;
      pc_q      <= pc_d;
      rd_en_q   <= rd_en_d;
      rd_vld_q  <= rd_vld_d;
      instr_q   <= instr_d;
      dcnt_q    <= dcnt_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign pmem.pmem_rd_en   = rd_en_q;
  assign pmem.pmem_rd_addr = pc_q;
  assign instr_out         = instr_q;
  assign overrun           = ovr_q;
  assign overrun_count     = ovr_cnt_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer. Each run_frame issues a tick in cycle T
// and records outputs for cycles T+1..T+ncyc; test tasks compare the trace
// against hand-derived timing. Overrun counter is narrowed to 3 bits so
// saturation is reachable.
module tb_dsp_sequencer;
  localparam int AW = 10;
  localparam int DW = 26;
  localparam int CW = 3;
  localparam int MAXC = 1040;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          sample_tick = 1'b0;
  logic          enable = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [DW-1:0] instr_out;
  logic          busy, frame_done, overrun, overrun_clr = 1'b0;
  logic [CW-1:0] overrun_count;

  int errors = 0;
  int checks = 0;

  dsp_sequencer_if #(.PROG_ADDR_WIDTH(AW), .INSTR_WIDTH(DW)) pm ();

  dsp_sequencer #(.OVR_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .enable(enable),
    .prog_len(prog_len), .pmem(pm), .instr_out(instr_out), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .overrun_count(overrun_count),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int a);
    logic [9:0] a10;
    a10 = a[9:0];
    return {6'h15, a10, 10'h2B5};
  endfunction

  // Synchronous-read program memory; junk when not reading.
  always @(posedge clk)
    pm.pmem_rd_data <= pm.pmem_rd_en ? word(int'(pm.pmem_rd_addr)) : 26'h2AAAAAA;

  // per-cycle stimulus events and captured trace, index = cycles after T
  bit            tick_v [0:MAXC-1];
  bit            clr_v  [0:MAXC-1];
  int            en_drop, rst_at, plen_chg;
  logic          t_en   [0:MAXC-1];
  logic [AW-1:0] t_addr [0:MAXC-1];
  logic [DW-1:0] t_instr[0:MAXC-1];
  logic          t_busy [0:MAXC-1];
  logic          t_fd   [0:MAXC-1];
  logic          t_ovr  [0:MAXC-1];
  logic [CW-1:0] t_cnt  [0:MAXC-1];

  task automatic clear_ev();
    for (int i = 0; i < MAXC; i++) begin tick_v[i] = 0; clr_v[i] = 0; end
    en_drop = -1; rst_at = -1; plen_chg = -1;
  endtask

  task automatic run_frame(input logic [AW:0] plen, input logic en_t, input int ncyc);
    @(negedge clk);
    prog_len = plen; enable = en_t; sample_tick = 1'b1; overrun_clr = 1'b0;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      sample_tick = tick_v[j];
      overrun_clr = clr_v[j];
      enable      = !(en_drop >= 0 && j >= en_drop);
      reset_n     = (j != rst_at);
      if (j == plen_chg) prog_len = 11'd7;
      #1;
      t_en[j] = pm.pmem_rd_en; t_addr[j] = pm.pmem_rd_addr; t_instr[j] = instr_out;
      t_busy[j] = busy; t_fd[j] = frame_done; t_ovr[j] = overrun; t_cnt[j] = overrun_count;
    end
    @(negedge clk);
    sample_tick = 1'b0; overrun_clr = 1'b0; reset_n = 1'b1; enable = 1'b1;
    clear_ev();
  endtask

  // Full trace check for a short frame of n instructions.
  task automatic check_frame(input string nm, input int n, input int ncyc);
    logic          ee, eb, ef;
    logic [DW-1:0] ei;
    for (int j = 1; j <= ncyc; j++) begin
      ee = (j >= 1 && j <= n);
      ei = (j >= 3 && j < 3 + n) ? word(j - 3) : '0;
      eb = (j <= 7 + n);
      ef = (j == 7 + n);
      checks++; if (t_en[j] !== ee) begin errors++; $display("FAIL %s rd_en[T+%0d] got %b want %b", nm, j, t_en[j], ee); end
      if (ee) begin
        checks++; if (t_addr[j] !== AW'(j - 1)) begin errors++; $display("FAIL %s rd_addr[T+%0d] got %0d want %0d", nm, j, t_addr[j], j - 1); end
      end
      checks++; if (t_instr[j] !== ei) begin errors++; $display("FAIL %s instr[T+%0d] got %h want %h", nm, j, t_instr[j], ei); end
      checks++; if (t_busy[j] !== eb) begin errors++; $display("FAIL %s busy[T+%0d] got %b want %b", nm, j, t_busy[j], eb); end
      checks++; if (t_fd[j] !== ef) begin errors++; $display("FAIL %s frame_done[T+%0d] got %b want %b", nm, j, t_fd[j], ef); end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b want 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b want 0", overrun); end
    checks++; if (overrun_count !== '0) begin errors++; $display("FAIL rst_cnt got %0d want 0", overrun_count); end
    checks++; if (pm.pmem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b want 0", pm.pmem_rd_en); end
    checks++; if (pm.pmem_rd_addr !== '0) begin errors++; $display("FAIL rst_addr got %0d want 0", pm.pmem_rd_addr); end
    checks++; if (instr_out !== '0) begin errors++; $display("FAIL rst_instr got %h want 0", instr_out); end
    reset_n = 1'b1; enable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    run_frame(11'd3, 1'b1, 12);
    check_frame("basic", 3, 12);
    checks++; if (t_ovr[12] !== 1'b0) begin errors++; $display("FAIL basic_ovr got %b want 0", t_ovr[12]); end
  endtask

  task automatic test_zero_len();
    run_frame(11'd0, 1'b1, 10);
    check_frame("zero", 0, 10);
  endtask

  task automatic test_enable();
    run_frame(11'd3, 1'b0, 6);
    for (int j = 1; j <= 6; j++) begin
      checks++; if (t_busy[j] !== 1'b0) begin errors++; $display("FAIL en0_busy[T+%0d] got %b want 0", j, t_busy[j]); end
      checks++; if (t_en[j] !== 1'b0) begin errors++; $display("FAIL en0_rd_en[T+%0d] got %b want 0", j, t_en[j]); end
    end
    checks++; if (t_ovr[6] !== 1'b0) begin errors++; $display("FAIL en0_ovr got %b want 0", t_ovr[6]); end
    en_drop = 2;
    run_frame(11'd3, 1'b1, 12);
    check_frame("en_drop", 3, 12);
  endtask

  task automatic test_prog_len_change();
    plen_chg = 1;
    run_frame(11'd3, 1'b1, 12);
    check_frame("plen_chg", 3, 12);
  endtask

  task automatic test_overrun();
    tick_v[5] = 1; tick_v[10] = 1;
    run_frame(11'd3, 1'b1, 16);
    check_frame("ovr", 3, 16);
    checks++; if (t_cnt[6] !== 3'd1) begin errors++; $display("FAIL ovr_cnt_first got %0d want 1", t_cnt[6]); end
    checks++; if (t_ovr[16] !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", t_ovr[16]); end
    checks++; if (t_cnt[16] !== 3'd2) begin errors++; $display("FAIL ovr_cnt got %0d want 2", t_cnt[16]); end
    // clear while idle (tick with enable low is not an overrun)
    clr_v[1] = 1;
    run_frame(11'd3, 1'b0, 3);
    checks++; if (t_ovr[2] !== 1'b0) begin errors++; $display("FAIL clr_ovr got %b want 0", t_ovr[2]); end
    checks++; if (t_cnt[2] !== 3'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", t_cnt[2]); end
    // clear coincident with an overrun tick
    tick_v[2] = 1; tick_v[4] = 1; clr_v[4] = 1;
    run_frame(11'd3, 1'b1, 12);
    checks++; if (t_cnt[3] !== 3'd1) begin errors++; $display("FAIL sim_pre_cnt got %0d want 1", t_cnt[3]); end
    checks++; if (t_cnt[5] !== 3'd1) begin errors++; $display("FAIL sim_clr_cnt got %0d want 1", t_cnt[5]); end
    checks++; if (t_ovr[5] !== 1'b1) begin errors++; $display("FAIL sim_clr_ovr got %b want 1", t_ovr[5]); end
  endtask

  task automatic test_saturate();
    clr_v[1] = 1;
    for (int j = 2; j <= 12; j++) tick_v[j] = 1;
    run_frame(11'd10, 1'b1, 20);
    checks++; if (t_cnt[2] !== 3'd0) begin errors++; $display("FAIL sat_start got %0d want 0", t_cnt[2]); end
    checks++; if (t_cnt[8] !== 3'd6) begin errors++; $display("FAIL sat_mid got %0d want 6", t_cnt[8]); end
    checks++; if (t_cnt[9] !== 3'd7) begin errors++; $display("FAIL sat_full got %0d want 7", t_cnt[9]); end
    checks++; if (t_cnt[13] !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d want 7", t_cnt[13]); end
    checks++; if (t_fd[17] !== 1'b1) begin errors++; $display("FAIL sat_fd got %b want 1", t_fd[17]); end
  endtask

  task automatic test_reset_midframe();
    int fds;
    rst_at = 3;
    run_frame(11'd3, 1'b1, 12);
    checks++; if (t_busy[3] !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", t_busy[3]); end
    checks++; if (t_en[3] !== 1'b0) begin errors++; $display("FAIL mrst_rd_en got %b want 0", t_en[3]); end
    checks++; if (t_addr[3] !== '0) begin errors++; $display("FAIL mrst_addr got %0d want 0", t_addr[3]); end
    checks++; if (t_instr[3] !== '0) begin errors++; $display("FAIL mrst_instr got %h want 0", t_instr[3]); end
    checks++; if (t_ovr[3] !== 1'b0) begin errors++; $display("FAIL mrst_ovr got %b want 0", t_ovr[3]); end
    checks++; if (t_cnt[3] !== '0) begin errors++; $display("FAIL mrst_cnt got %0d want 0", t_cnt[3]); end
    fds = 0;
    for (int j = 3; j <= 12; j++) begin
      fds += int'(t_fd[j]);
      checks++; if (t_instr[j] !== '0) begin errors++; $display("FAIL mrst_instr_after[T+%0d] got %h want 0", j, t_instr[j]); end
    end
    checks++; if (fds != 0) begin errors++; $display("FAIL mrst_no_fd got %0d pulses want 0", fds); end
    run_frame(11'd3, 1'b1, 12);
    check_frame("after_rst", 3, 12);
  endtask

  task automatic test_full(input logic [AW:0] plen, input string nm);
    int nen, nzero, nfd;
    run_frame(plen, 1'b1, 1034);
    nen = 0; nzero = 0; nfd = 0;
    for (int j = 1; j <= 1034; j++) begin
      nen += int'(t_en[j]);
      if (t_en[j] && t_addr[j] == '0) nzero++;
      nfd += int'(t_fd[j]);
    end
    checks++; if (nen != 1024) begin errors++; $display("FAIL %s fetches got %0d want 1024", nm, nen); end
    checks++; if (nzero != 1) begin errors++; $display("FAIL %s addr0_reads got %0d want 1", nm, nzero); end
    checks++; if (t_en[1024] !== 1'b1 || t_addr[1024] !== 10'd1023) begin errors++; $display("FAIL %s last_fetch got en=%b addr=%0d want en=1 addr=1023", nm, t_en[1024], t_addr[1024]); end
    checks++; if (t_en[1025] !== 1'b0) begin errors++; $display("FAIL %s rd_en_after got %b want 0", nm, t_en[1025]); end
    checks++; if (t_instr[1026] !== word(1023)) begin errors++; $display("FAIL %s last_instr got %h want %h", nm, t_instr[1026], word(1023)); end
    checks++; if (t_fd[1031] !== 1'b1) begin errors++; $display("FAIL %s fd_1031 got %b want 1", nm, t_fd[1031]); end
    checks++; if (nfd != 1) begin errors++; $display("FAIL %s fd_count got %0d want 1", nm, nfd); end
    checks++; if (t_busy[1032] !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", nm, t_busy[1032]); end
  endtask

  initial begin
    clear_ev();
    test_reset();
    test_basic();
    test_zero_len();
    test_enable();
    test_prog_len_change();
    test_overrun();
    test_saturate();
    test_reset_midframe();
    test_full(11'd1024, "full");
    test_full(11'd2047, "clamp");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
